// File: rtl/muldiv_sched_pkg.sv
// rtl/muldiv_sched_pkg.sv - shared op codes, state encoding and counter sizing for muldiv_sched
package muldiv_sched_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        int longest;
        longest = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// rtl/muldiv_sched_if.sv - E-stage mult/div issue, HI/LO access and stall handshake bundle
interface muldiv_sched_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] wdata;
    logic        md_use_D;
    logic        busy;
    logic        done;
    logic        stall_D;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_write, lo_write, wdata, md_use_D,
        input  busy, done, stall_D, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_write, lo_write, wdata, md_use_D,
        output busy, done, stall_D, hi, lo
    );
endinterface

// File: rtl/muldiv_sched_md_compute.sv
// rtl/muldiv_sched_md_compute.sv - combinational mult/multu/div/divu datapath producing the pending HI/LO pair
module md_compute
    import muldiv_sched_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] pend_hi,
    output logic [31:0] pend_lo,
    output logic        div_by_zero
);

    logic [63:0] prod;
    logic        signed_op;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quot;
    logic [31:0] rem;

    // Division runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    always_comb begin
        prod        = 64'd0;
        signed_op   = (op == MD_DIV);
        neg_a       = signed_op & a[31];
        neg_b       = signed_op & b[31];
        mag_a       = neg_a ? (32'd0 - a) : a;
        mag_b       = neg_b ? (32'd0 - b) : b;
        div_by_zero = op[1] & (b == 32'd0);
        divisor     = (b == 32'd0) ? 32'd1 : mag_b;
        quot        = mag_a / divisor;
        rem         = mag_a % divisor;
        pend_hi     = 32'd0;
        pend_lo     = 32'd0;
        case (op)
            MD_MULT: begin
                prod    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                pend_hi = prod[63:32];
                pend_lo = prod[31:0];
            end
            MD_MULTU: begin
                prod    = {32'd0, a} * {32'd0, b};
                pend_hi = prod[63:32];
                pend_lo = prod[31:0];
            end
            default: begin
                pend_lo = (neg_a ^ neg_b) ? (32'd0 - quot) : quot;
                pend_hi = neg_a ? (32'd0 - rem) : rem;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - multiply/divide scheduler: busy window, HI/LO commit and D-stage stall request
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_sched_if.slave  bus
);

    localparam int CW = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e   state;
    logic [CW-1:0] cnt;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_dz;

    logic [31:0] c_hi;
    logic [31:0] c_lo;
    logic        c_dz;

    md_compute u_compute (
        .op          (bus.op),
        .a           (bus.a),
        .b           (bus.b),
        .pend_hi     (c_hi),
        .pend_lo     (c_lo),
        .div_by_zero (c_dz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start shadows any mthi/mtlo issued in the same cycle.
                    if (bus.start) begin
                        pend_hi <= c_hi;
                        pend_lo <= c_lo;
                        pend_dz <= c_dz;
                        cnt     <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        if (bus.hi_write) hi_q <= bus.wdata;
                        if (bus.lo_write) lo_q <= bus.wdata;
                    end
                end
                ST_RUN: begin
                    if (cnt == CW'(1)) begin
                        if (!pend_dz) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Includes the start cycle so an mflo right behind its mult is held in D.
    assign bus.stall_D = bus.md_use_D & (bus.start | busy_q);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - randomized self-checking bench for muldiv_sched against a behavioural HI/LO model
module tb_muldiv_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    muldiv_sched_if bus();

    muldiv_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Architectural effect of one mult/div on the reference HI/LO pair.
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: begin p = sa * sb; ref_hi = p[63:32]; ref_lo = p[31:0]; end
            2'd1: begin up = ua * ub; ref_hi = up[63:32]; ref_lo = up[31:0]; end
            2'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                ref_lo = q[31:0]; ref_hi = r[31:0];
            end
            default: if (b != 0) begin
                up = ua / ub; ref_lo = up[31:0];
                up = ua % ub; ref_hi = up[31:0];
            end
        endcase
    endtask

    task automatic clear_inputs();
        bus.start = 1'b0; bus.hi_write = 1'b0; bus.lo_write = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit use_d, input bit start_write, input bit run_poke);
        int n;
        n = op[1] ? DC : MC;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.md_use_D = use_d;
        if (start_write) begin
            bus.lo_write = 1'b1; bus.hi_write = 1'($urandom_range(1)); bus.wdata = $urandom;
        end
        @(negedge clk);
        check("start_stall", {31'd0, bus.stall_D}, {31'd0, use_d});
        check("start_busy", {31'd0, bus.busy}, 32'd0);
        check("start_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk); #1;
        for (int k = 1; k <= n; k++) begin
            clear_inputs();
            bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
            if (run_poke && k == 2) begin
                bus.start = 1'b1; bus.hi_write = 1'b1; bus.lo_write = 1'b1; bus.wdata = $urandom;
            end
            @(negedge clk);
            check("run_busy", {31'd0, bus.busy}, 32'd1);
            check("run_done", {31'd0, bus.done}, 32'd0);
            check("run_stall", {31'd0, bus.stall_D}, {31'd0, use_d});
            check("run_hi_hold", bus.hi, ref_hi);
            check("run_lo_hold", bus.lo, ref_lo);
            @(posedge clk); #1;
        end
        model_op(op, a, b);
        @(negedge clk);
        check("commit_done", {31'd0, bus.done}, 32'd1);
        check("commit_busy", {31'd0, bus.busy}, 32'd0);
        check("commit_stall", {31'd0, bus.stall_D}, 32'd0);
        check("commit_hi", bus.hi, ref_hi);
        check("commit_lo", bus.lo, ref_lo);
        bus.md_use_D = 1'b0;
    endtask

    task automatic move_to(input bit hw, input bit lw, input logic [31:0] data);
        @(posedge clk); #1;
        bus.hi_write = hw; bus.lo_write = lw; bus.wdata = data; bus.md_use_D = 1'b1;
        @(negedge clk);
        check("mt_stall", {31'd0, bus.stall_D}, 32'd0);
        @(posedge clk); #1;
        clear_inputs(); bus.md_use_D = 1'b0;
        if (hw) ref_hi = data;
        if (lw) ref_lo = data;
        @(negedge clk);
        check("mt_hi", bus.hi, ref_hi);
        check("mt_lo", bus.lo, ref_lo);
    endtask

    initial begin
        clear_inputs();
        bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0; bus.wdata = 32'd0; bus.md_use_D = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;

        run_op(2'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        check("t1_hi", bus.hi, 32'hFFFFFFFF);
        check("t1_lo", bus.lo, 32'hFFFFFFFA);
        run_op(2'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        check("t2_hi", bus.hi, 32'h00000001);
        check("t2_lo", bus.lo, 32'hFFFFFFFE);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check("t3_hi", bus.hi, 32'hFFFFFFFF);
        check("t3_lo", bus.lo, 32'hFFFFFFFD);
        run_op(2'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        check("t3z_hi", bus.hi, 32'hFFFFFFFF);
        check("t3z_lo", bus.lo, 32'hFFFFFFFD);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("ovf_hi", bus.hi, 32'h00000000);
        check("ovf_lo", bus.lo, 32'h80000000);

        run_op(2'd0, 32'd12, 32'd34, 1'b1, 1'b0, 1'b0);
        run_op(2'd0, 32'd56, 32'd78, 1'b0, 1'b0, 1'b0);

        move_to(1'b1, 1'b0, 32'h00001234);
        check("t5_hi", bus.hi, 32'h00001234);
        run_op(2'd0, 32'h00010001, 32'h00000003, 1'b0, 1'b1, 1'b0);
        run_op(2'd1, 32'hDEADBEEF, 32'h0BADF00D, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            if ($urandom_range(7) == 0) rb = 32'd0;
            if ($urandom_range(5) == 0) rb = 32'hFFFFFFFF;
            if ($urandom_range(3) == 0) move_to(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
            run_op(2'($urandom), ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        move_to(1'b1, 1'b1, 32'h5A5A0F0F);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd100; bus.b = 32'd3;
        @(posedge clk); #1;
        clear_inputs();
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        ref_hi = 32'd0; ref_lo = 32'd0;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_hi", bus.hi, ref_hi);
        check("arst_lo", bus.lo, ref_lo);
        @(negedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check("post_rst_done", {31'd0, bus.done}, 32'd0);
            check("post_rst_hi", bus.hi, ref_hi);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
